ebus_xfer: RTL and testbench
============================

EBUS_XFER -- requirements
Module: ebus_xfer

Interface
REQ-001 Parameter SETUP_CYC, default 2, cycles CS/FUNC (and write data) are driven before DEMAND asserts.
REQ-002 Parameter TIMEOUT_CYC, default 15, maximum DEMAND cycles waiting for XFER; also bounds the RELEASE wait.
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port CROBAR, input, 1, reset, synchronous and active-high.
REQ-005 Port req, input, 1, EBOX request to start one EBUS I/O cycle.
REQ-006 Port func, input, [0:2], I/O function: 0 CONI, 1 CONO, 2 DATAI, 3 DATAO, 4-7 illegal.
REQ-007 Port cs, input, [0:6], device controller select.
REQ-008 Port wdata, input, [0:35], data for CONO/DATAO.
REQ-009 Port ebusData, input, [0:35], muxed EBUS data lines.
REQ-010 Port xfer, input, 1, device transfer acknowledge.
REQ-011 Port ebusCS, output, [0:6], select driven onto EBUS.
REQ-012 Port ebusFunc, output, [0:2], function driven onto EBUS.
REQ-013 Port demand, output, 1, EBUS demand.
REQ-014 Port driving, output, 1, EBUSdriver enable into the EBUS data mux.
REQ-015 Port drvData, output, [0:35], EBUSdriver data.
REQ-016 Port busy, output, 1, cycle in progress.
REQ-017 Port done, output, 1, one-cycle completion pulse.
REQ-018 Port timeout, output, 1, last cycle ended without XFER or was illegal; valid with done, held until next accepted req.
REQ-019 Port rdata, output, [0:35], read result; valid with done, held until next accepted req.

Function
REQ-020 States: IDLE, SETUP, DEMAND, RELEASE, DONE; one-hot or encoded is allowed.
REQ-021 IDLE: req high accepts the cycle; func/cs/wdata latched; busy=1 from next cycle; timeout and rdata cleared; legal func -> SETUP; illegal func -> DONE with timeout=1, no EBUS activity.
REQ-022 req while busy, or while in DONE, is ignored and not queued.
REQ-023 SETUP: ebusCS/ebusFunc driven from latches; for writes (func 1,3) driving=1 and drvData=latched wdata; after exactly SETUP_CYC cycles -> DEMAND.
REQ-024 ebusCS, ebusFunc, driving and drvData hold through SETUP, DEMAND and RELEASE; all are 0 in IDLE and DONE.
REQ-025 DEMAND: demand=1; the counter starts at 0 and increments each cycle.
REQ-026 DEMAND exit on xfer=1: reads (func 0,2) latch ebusData into rdata that same edge -> RELEASE.
REQ-027 DEMAND exit on timeout: when the counter reaches TIMEOUT_CYC-1 with xfer=0 -> RELEASE, timeout=1, rdata=0.
REQ-028 When xfer and the timeout occur in the same cycle, xfer wins; timeout stays 0.
REQ-029 RELEASE: demand=0; wait for xfer=0, then -> DONE.
REQ-030 RELEASE bound: if xfer stays high for TIMEOUT_CYC cycles -> DONE with timeout=1; rdata is kept.
REQ-031 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-032 Latency, legal cycle with xfer answered in cycle k of DEMAND (k=0 first) and dropped immediately: done asserts SETUP_CYC+k+3 cycles after the req edge.
REQ-033 A minimum of one IDLE cycle separates consecutive cycles.

Reset
REQ-034 CROBAR=1 at a clk edge forces IDLE, counter=0 and all outputs to 0, including rdata and timeout; this overrides any state, including mid-cycle.
REQ-035 While CROBAR=1, req is ignored; the first request is accepted on the first edge with CROBAR=0.

Verification
REQ-036 CONO: func=1, cs=7'o4, wdata=36'o123456654321, xfer rises 3 cycles after demand and falls 1 cycle later -> driving=1 with drvData=123456654321 through RELEASE, done once, timeout=0.
REQ-037 DATAI: func=2, ebusData=36'o777000111222 while xfer=1 -> rdata=777000111222 at done, driving never 1.
REQ-038 No xfer, TIMEOUT_CYC=15: demand high exactly 15 cycles, then done with timeout=1 and rdata=0.
REQ-039 func=5 -> done 1 cycle after accept, timeout=1, demand and driving never assert.
REQ-040 CROBAR pulsed during DEMAND of a DATAO -> next cycle all outputs 0; a new CONI accepted after reset completes normally.
REQ-041 xfer held high after demand drops, TIMEOUT_CYC=15 -> done after 15 RELEASE cycles with timeout=1; req pulses while busy produce no extra done.

Source files
------------

// File: rtl/ebus_xfer.sv
// EBUS I/O cycle sequencer: drives CS/FUNC/data, raises DEMAND, waits for XFER,
// then waits for XFER to drop before signalling completion.
module ebus_xfer #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        req,
  input  logic [0:2]  func,
  input  logic [0:6]  cs,
  input  logic [0:35] wdata,
  input  logic [0:35] ebusData,
  input  logic        xfer,
  output logic [0:6]  ebusCS,
  output logic [0:2]  ebusFunc,
  output logic        demand,
  output logic        driving,
  output logic [0:35] drvData,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [0:35] rdata
);

  localparam int CMAX = (SETUP_CYC > TIMEOUT_CYC) ? SETUP_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, DEMAND, RELEASE, DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [0:2]    func_q;
  logic [0:6]    cs_q;
  logic [0:35]   wdata_q;
  logic          to_nxt;
  logic [0:35]   rd_nxt;
  logic          latch;
  logic          active;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state   <= IDLE;
      cnt     <= '0;
      func_q  <= '0;
      cs_q    <= '0;
      wdata_q <= '0;
      timeout <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      timeout <= to_nxt;
      rdata   <= rd_nxt;
      if (latch) begin
        func_q  <= func;
        cs_q    <= cs;
        wdata_q <= wdata;
      end
    end
  end

  // func values 4-7 (MSB set) are illegal and complete at once with timeout.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    to_nxt  = timeout;
    rd_nxt  = rdata;
    latch   = 1'b0;
    case (state)
      IDLE: if (req) begin
        latch   = 1'b1;
        to_nxt  = 1'b0;
        rd_nxt  = '0;
        cnt_nxt = '0;
        if (func[0]) begin
          nxt    = DONE;
          to_nxt = 1'b1;
        end else begin
          nxt = SETUP;
        end
      end
      SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
        nxt     = DEMAND;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      DEMAND: if (xfer) begin
        nxt     = RELEASE;
        cnt_nxt = '0;
        if (!func_q[2]) rd_nxt = ebusData;
      end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
        nxt     = RELEASE;
        cnt_nxt = '0;
        to_nxt  = 1'b1;
        rd_nxt  = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      RELEASE: if (!xfer) begin
        nxt     = DONE;
        cnt_nxt = '0;
      end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
        nxt     = DONE;
        cnt_nxt = '0;
        to_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus-facing outputs are gated so they read zero outside the active window.
  assign active   = (state == SETUP) || (state == DEMAND) || (state == RELEASE);
  assign busy     = active;
  assign demand   = (state == DEMAND);
  assign done     = (state == DONE);
  assign ebusCS   = active ? cs_q : '0;
  assign ebusFunc = active ? func_q : '0;
  assign driving  = active && func_q[2];
  assign drvData  = driving ? wdata_q : '0;

endmodule

// File: tb/tb_ebus_xfer.sv
// Directed bench for ebus_xfer: scripted device responder, scoreboard of
// expected {timeout, rdata} popped at each done pulse.
module tb_ebus_xfer;

  logic        clk;
  logic        CROBAR;
  logic        req;
  logic [0:2]  func;
  logic [0:6]  cs;
  logic [0:35] wdata;
  logic [0:35] ebusData;
  logic        xfer;
  logic [0:6]  ebusCS;
  logic [0:2]  ebusFunc;
  logic        demand;
  logic        driving;
  logic [0:35] drvData;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [0:35] rdata;

  int ncmp = 0;
  int nerr = 0;
  logic [36:0] sb[$];

  ebus_xfer #(.SETUP_CYC(2), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .CROBAR(CROBAR), .req(req), .func(func), .cs(cs), .wdata(wdata),
    .ebusData(ebusData), .xfer(xfer), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
    .demand(demand), .driving(driving), .drvData(drvData), .busy(busy),
    .done(done), .timeout(timeout), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {busy, demand, driving, done, timeout}, 0);
    chk({tag, "_drvdata"}, drvData, 0);
    chk({tag, "_csfunc"}, {ebusCS, ebusFunc}, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One complete I/O cycle. The responder raises xfer in demand cycle dly
  // (dly<0: never) and holds it for hold sampling edges.
  task automatic xact(input logic [2:0] f, input logic [6:0] c, input logic [35:0] wd,
                      input int dly, input int hold, input logic [35:0] bd,
                      input logic exp_to, input logic [35:0] exp_rd,
                      input int exp_lat, input int exp_dem, input bit pulse);
    int n, dcyc, hcnt, dem;
    bit drv_seen, drv_bad, got, xon;
    logic [36:0] e;
    sb.push_back({exp_to, exp_rd});
    func = f; cs = c; wdata = wd; ebusData = ~bd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0; dcyc = 0; hcnt = 0; dem = 0;
    drv_seen = 0; drv_bad = 0; got = 0; xon = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      else begin
        if (demand) dem++;
        if (driving) begin
          drv_seen = 1;
          if (drvData !== wd || ebusCS !== c || ebusFunc !== f) drv_bad = 1;
        end
        if (xon) begin
          hcnt++;
          if (hcnt >= hold) xfer = 1'b0;
        end else if (demand && dly >= 0) begin
          if (dcyc == dly) begin
            xfer = 1'b1; ebusData = bd; xon = 1;
          end
          dcyc++;
        end
        if (pulse) req = (n % 3 == 1);
      end
    end
    req = 1'b0;
    xfer = 1'b0;
    chk("done_seen", got, 1);
    if (got) begin
      e = sb.pop_front();
      chk("timeout", timeout, e[36]);
      chk("rdata", rdata, e[35:0]);
    end
    chk("busy_at_done", busy, 0);
    chk("latency", n, exp_lat);
    chk("demand_cycles", dem, exp_dem);
    chk("driving_seen", drv_seen, (f == 3'd1 || f == 3'd3));
    chk("drive_values", drv_bad, 0);
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 0);
    chk("result_held", {timeout, rdata}, {exp_to, exp_rd});
    chk("bus_idle", {ebusCS, ebusFunc, driving, demand}, 0);
  endtask

  initial begin
    int n;
    CROBAR = 1'b1; req = 1'b0; func = '0; cs = '0; wdata = '0;
    ebusData = '0; xfer = 1'b0;
    @(posedge clk); #1;
    // request held during reset must be ignored
    req = 1'b1; func = 3'd1; cs = 7'o4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    CROBAR = 1'b0;
    @(negedge clk);
    chk("accept_after_reset", busy, 1);
    chk("cs_after_reset", ebusCS, 7'o4);
    req = 1'b0; CROBAR = 1'b1;
    @(negedge clk);
    chk_idle("abort_setup");
    CROBAR = 1'b0;
    @(negedge clk);

    // CONO: xfer 3 cycles after demand, 1 cycle wide
    xact(3'd1, 7'o4, 36'o123456654321, 3, 1, 36'o0, 1'b0, 36'o0, 8, 4, 0);
    // DATAI answered at once
    xact(3'd2, 7'o11, 36'o0, 0, 1, 36'o777000111222, 1'b0, 36'o777000111222, 5, 1, 0);
    // no xfer: demand timeout
    xact(3'd0, 7'o5, 36'o0, -1, 1, 36'o55, 1'b1, 36'o0, 19, 15, 0);
    // illegal function
    xact(3'd5, 7'o3, 36'o1, -1, 1, 36'o0, 1'b1, 36'o0, 1, 0, 0);
    // xfer on the last demand cycle beats the timeout
    xact(3'd2, 7'o17, 36'o0, 14, 1, 36'o101010202020, 1'b0, 36'o101010202020, 19, 15, 0);

    // reset in the middle of a DATAO demand phase
    func = 3'd3; cs = 7'o22; wdata = 36'o765432101234; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (n < 50 && !demand) begin
      @(negedge clk);
      n++;
    end
    chk("reached_demand", demand, 1);
    CROBAR = 1'b1;
    @(posedge clk); #1;
    CROBAR = 1'b0;
    @(negedge clk);
    chk_idle("reset_mid_demand");
    xact(3'd0, 7'o6, 36'o0, 1, 1, 36'o13, 1'b0, 36'o13, 6, 2, 0);

    // xfer stuck high through release, with req pulses while busy
    xact(3'd0, 7'o7, 36'o0, 0, 1000, 36'o246, 1'b1, 36'o246, 19, 1, 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_done", {done, busy}, 0);
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
